// File: rtl/radix4_divider.sv
// Sequential radix-4 digit-recurrence divider.
// A 2N-bit unsigned dividend is divided by an N-bit unsigned divisor.
// Each clock retires one quotient digit (0..3) by comparing the partial
// remainder against the precomputed multiples D, 2D and 3D.
module radix4_divider #(
    parameter int N = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2*N-1:0]   dividend,
    input  logic [N-1:0]     divisor,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   quotient,
    output logic [N-1:0]     remainder,
    output logic             div_by_zero
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_reg, state_next;
    logic [2*N-1:0] dvd_reg;          // dividend shift register, MSBs consumed first
    logic [2*N-1:0] acc_reg;          // quotient accumulator
    logic [N-1:0]   d_reg;            // divisor D
    logic [N+1:0]   d3_reg;           // 3D, precomputed at accept time
    logic [N-1:0]   r_reg;            // partial remainder, always < D
    logic [CW-1:0]  cnt_reg;
    logic [2*N-1:0] quotient_reg;
    logic [N-1:0]   remainder_reg;
    logic           dbz_reg;

    logic           accept;
    logic           last_iter;
    logic [N+1:0]   t_val;
    logic [N+1:0]   mult [1:3];
    logic [3:1]     ge;
    logic [1:0]     digit;
    logic [N+1:0]   sub_val;
    logic [N-1:0]   r_new;

    // A new request is only taken when not iterating.
    assign accept    = start && (state_reg != CALC);
    assign last_iter = (cnt_reg == CW'(N - 1));

    // Trial value: remainder with the next two dividend bits shifted in.
    assign t_val   = {r_reg, dvd_reg[2*N-1 -: 2]};
    assign mult[1] = {2'b00, d_reg};
    assign mult[2] = {1'b0, d_reg, 1'b0};
    assign mult[3] = d3_reg;

    // One comparator per divisor multiple.
    generate
        for (genvar gi = 1; gi <= 3; gi++) begin : g_cmp
            assign ge[gi] = (t_val >= mult[gi]);
        end
    endgenerate

    // Pick the largest multiple not exceeding the trial value.
    always_comb begin
        digit   = 2'd0;
        sub_val = '0;
        if (ge[3]) begin
            digit   = 2'd3;
            sub_val = mult[3];
        end else if (ge[2]) begin
            digit   = 2'd2;
            sub_val = mult[2];
        end else if (ge[1]) begin
            digit   = 2'd1;
            sub_val = mult[1];
        end
    end

    // Result fits in N bits because T < 4D and the chosen multiple leaves < D.
    assign r_new = N'(t_val - sub_val);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; a zero divisor short-circuits straight to DONE.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next = (divisor == '0) ? DONE : CALC;
                end else begin
                    state_next = IDLE;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, one digit per CALC edge, result load on DONE entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_reg       <= '0;
            acc_reg       <= '0;
            d_reg         <= '0;
            d3_reg        <= '0;
            r_reg         <= '0;
            cnt_reg       <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
        end else if (accept) begin
            if (divisor != '0) begin
                dvd_reg <= dividend;
                d_reg   <= divisor;
                d3_reg  <= {2'b00, divisor} + {1'b0, divisor, 1'b0};
                r_reg   <= '0;
                acc_reg <= '0;
                cnt_reg <= '0;
            end else begin
                quotient_reg  <= '1;
                remainder_reg <= '0;
                dbz_reg       <= 1'b1;
            end
        end else if (state_reg == CALC) begin
            dvd_reg <= {dvd_reg[2*N-3:0], 2'b00};
            acc_reg <= {acc_reg[2*N-3:0], digit};
            r_reg   <= r_new;
            cnt_reg <= cnt_reg + 1'b1;
            if (last_iter) begin
                quotient_reg  <= {acc_reg[2*N-3:0], digit};
                remainder_reg <= r_new;
                dbz_reg       <= 1'b0;
            end
        end
    end

    assign busy        = (state_reg == CALC);
    assign done        = (state_reg == DONE);
    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_radix4_divider.sv
// Testbench for radix4_divider: scoreboard of expected results, checked on done.
module tb_radix4_divider;

    localparam int N  = 7;
    localparam int W2 = 2 * N;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [W2-1:0] dividend = '0;
    logic [N-1:0]  divisor = '0;
    logic          busy, done, div_by_zero;
    logic [W2-1:0] quotient;
    logic [N-1:0]  remainder;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W2-1:0] a;
        logic [N-1:0]  b;
        logic [W2-1:0] q;
        logic [N-1:0]  r;
        logic          z;
    } exp_t;

    exp_t sb[$];

    radix4_divider #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Result checker: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("txn %0d/%0d -> q=%0d r=%0d z=%0d (exp q=%0d r=%0d z=%0d)",
                         e.a, e.b, quotient, remainder, div_by_zero, e.q, e.r, e.z);
                check("quotient", 32'(quotient), 32'(e.q));
                check("remainder", 32'(remainder), 32'(e.r));
                check("div_by_zero", 32'(div_by_zero), 32'(e.z));
                if (e.b != 0) begin
                    check("invariant", 32'(quotient) * 32'(e.b) + 32'(remainder), 32'(e.a));
                    check("rem_lt_div", 32'(remainder < e.b), 32'd1);
                end
            end
        end
    end

    // Drive a request at the current negedge and optionally queue its expectation.
    task automatic launch(input logic [W2-1:0] a, input logic [N-1:0] b, input bit push);
        exp_t e;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        e.a = a;
        e.b = b;
        if (b == 0) begin
            e.q = '1;
            e.r = '0;
            e.z = 1'b1;
        end else begin
            e.q = W2'(int'(a) / int'(b));
            e.r = N'(int'(a) % int'(b));
            e.z = 1'b0;
        end
        if (push) sb.push_back(e);
    endtask

    // After launch: count cycles (start cycle = 1) until done is seen.
    task automatic wait_done(input logic [N-1:0] b, input bit chk_busy);
        int cyc;
        int nbusy;
        cyc = 1;
        nbusy = 0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        while (!done && cyc < 40) begin
            if (busy) nbusy++;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        check("latency", 32'(cyc), (b == 0) ? 32'd1 : 32'(N + 1));
        if (chk_busy) check("busy_cycles", 32'(nbusy), 32'(N));
    endtask

    task automatic run_div(input logic [W2-1:0] a, input logic [N-1:0] b);
        launch(a, b, 1'b1);
        wait_done(b, 1'b0);
    endtask

    initial begin
        int cyc;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);

        // Basic case with latency and busy-length checks, then done must drop.
        launch(100, 7, 1'b1);
        wait_done(7, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
        check("hold_quotient", 32'(quotient), 32'd14);

        run_div(16383, 127);
        run_div(16383, 1);
        run_div(5, 9);
        run_div(0, 3);
        run_div(1234, 0);
        run_div(100, 3);

        // Start during CALC is ignored.
        launch(1000, 13, 1'b1);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        dividend = 50;
        divisor  = 5;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("busy_mid", 32'(busy), 32'd1);
        check("stable_mid", 32'(quotient), 32'd33);
        cyc = 3;
        while (!done && cyc < 40) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        check("ignored_latency", 32'(cyc), 32'(N + 1));
        // Back-to-back: start in the DONE cycle.
        launch(50, 5, 1'b1);
        wait_done(5, 1'b0);

        // Reset mid-operation abandons the division.
        launch(9999, 11, 1'b0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_quotient", 32'(quotient), 32'd0);
        check("abort_remainder", 32'(remainder), 32'd0);
        check("abort_dbz", 32'(div_by_zero), 32'd0);
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
        end
        run_div(9999, 11);

        // Random sweep.
        for (int i = 0; i < 300; i++) begin
            logic [W2-1:0] ra;
            logic [N-1:0]  rb;
            ra = W2'($urandom);
            rb = N'($urandom);
            if (i % 50 == 7) rb = '0;
            run_div(ra, rb);
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("queue_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
